// File: rtl/intr_ctrl_if.sv
// Memory-bus port of the interrupt controller: single-cycle strobe access with
// combinational read data and acknowledge.
interface intr_ctrl_if;
  logic        stb;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] dtw;
  logic [31:0] dtr;
  logic        ack;

  modport master (output stb, output we, output addr, output dtw, input dtr, input ack);
  modport slave  (input stb, input we, input addr, input dtw, output dtr, output ack);
endinterface

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: per-line edge/level pending capture, enable mask, fixed
// lowest-index priority, single in-service request. INTC_SYNC_EN adds a 2-flop input sync.
module intr_ctrl #(
  parameter int unsigned NIRQ = 24
) (
  input  logic            clk,
  input  logic            reset,
  intr_ctrl_if.slave      bus,
  input  logic [NIRQ-1:0] irq_in,
  output logic            intrq,
  output logic [4:0]      vec,
  input  logic            intack
);

  localparam logic [2:0] AddrPend   = 3'd0;
  localparam logic [2:0] AddrEnable = 3'd1;
  localparam logic [2:0] AddrEdge   = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
  localparam logic [2:0] AddrEoi    = 3'd4;

  typedef enum logic [1:0] {StIdle, StReq, StInsvc} state_e;

  state_e          state_q;
  logic            intrq_q;
  logic [4:0]      vec_q;
  logic [4:0]      active_vec_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] en_q;
  logic [NIRQ-1:0] edge_q;
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] irq_s;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] ack_clr;
  logic [NIRQ-1:0] pe;
  logic            any_pe;
  logic [4:0]      low_vec;
  logic            wr;
  logic            wr_pend, wr_en, wr_edge, wr_eoi;
  logic [31:0]     rd_data;
  logic            unused_dtw;

`ifdef INTC_SYNC_EN
  logic [NIRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Upper write-data bits are unused when NIRQ < 32.
  assign unused_dtw = ^bus.dtw;

  assign wr      = bus.stb & bus.we;
  assign wr_pend = wr & (bus.addr == AddrPend);
  assign wr_en   = wr & (bus.addr == AddrEnable);
  assign wr_edge = wr & (bus.addr == AddrEdge);
  assign wr_eoi  = wr & (bus.addr == AddrEoi);

  assign rise = irq_s & ~irq_prev_q;
  assign w1c  = wr_pend ? bus.dtw[NIRQ-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NIRQ); i++) begin
      ack_clr[i] = (state_q == StReq) && intack && (vec_q == 5'(i));
    end
  end

  // Edge lines: sticky with clears, a new rise beats any clear in the same cycle.
  // Level lines: follow the sampled input.
  assign pend_d = (edge_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~edge_q & irq_s);

  assign pe     = pend_q & en_q;
  assign any_pe = |pe;

  always_comb begin
    low_vec = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (pe[i]) begin
        low_vec = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      en_q       <= '0;
      edge_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= irq_s;
      if (wr_en) begin
        en_q <= bus.dtw[NIRQ-1:0];
      end
      if (wr_edge) begin
        edge_q <= bus.dtw[NIRQ-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      intrq_q      <= 1'b0;
      vec_q        <= '0;
      active_vec_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          vec_q <= low_vec;
          if (any_pe) begin
            state_q <= StReq;
            intrq_q <= 1'b1;
          end
        end
        StReq: begin
          if (intack) begin
            // The registered vec is what the CPU saw, so it is the one taken.
            active_vec_q <= vec_q;
            state_q      <= StInsvc;
            intrq_q      <= 1'b0;
          end else begin
            vec_q <= low_vec;
            if (!any_pe) begin
              state_q <= StIdle;
              intrq_q <= 1'b0;
            end
          end
        end
        StInsvc: begin
          if (wr_eoi) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          intrq_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (!reset) begin
      case (bus.addr)
        AddrPend:   rd_data[NIRQ-1:0] = pend_q;
        AddrEnable: rd_data[NIRQ-1:0] = en_q;
        AddrEdge:   rd_data[NIRQ-1:0] = edge_q;
        AddrStatus: rd_data = {23'b0, (state_q == StInsvc), intrq_q, 2'b0, active_vec_q};
        default:    rd_data = '0;
      endcase
    end
  end

  assign bus.dtr = rd_data;
  assign bus.ack = bus.stb;
  assign intrq   = intrq_q;
  assign vec     = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: register-map vector table, directed interrupt sequences and a
// randomized run, all checked against a cycle-level reference model of the controller.
module tb_intr_ctrl;

  localparam int NIRQ = 24;
`ifdef INTC_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NIRQ-1:0] irq_in;
  logic            intack;
  logic            intrq;
  logic [4:0]      vec;

  intr_ctrl_if bus ();

  intr_ctrl #(.NIRQ(NIRQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq_in (irq_in),
    .intrq  (intrq),
    .vec    (vec),
    .intack (intack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit [NIRQ-1:0] m_pend, m_en, m_edge, m_prev;
  bit            m_busy, m_intrq;
  int            m_vec, m_av;
  bit [NIRQ-1:0] m_dly[$];

  typedef struct {
    bit        we;
    bit [2:0]  addr;
    bit [31:0] dtw;
    bit [31:0] exp;
  } reg_vec_t;

  reg_vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic bit [31:0] exp_read(input int a);
    if (reset) return 32'h0;
    case (a)
      0: return 32'(m_pend);
      1: return 32'(m_en);
      2: return 32'(m_edge);
      3: return (32'(m_busy) << 8) | (32'(m_intrq) << 7) | 32'(m_av);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_edge = '0; m_prev = '0;
    m_busy = 1'b0; m_intrq = 1'b0; m_vec = 0; m_av = 0;
    m_dly.delete();
    for (int i = 0; i < SYNC_D; i++) m_dly.push_back('0);
  endtask

  // One clock: predict from the inputs held this cycle, advance, compare outputs.
  task automatic cycle();
    bit [NIRQ-1:0] samp, np, ne, ned, pe;
    bit            wr, nb, ni;
    int            nv, na;
    bit            was_reset;
    was_reset = reset;
    samp = '0; np = m_pend; ne = m_en; ned = m_edge;
    nb = m_busy; ni = m_intrq; nv = m_vec; na = m_av;
    if (!was_reset) begin
      m_dly.push_back(irq_in);
      samp = m_dly.pop_front();
      wr = bus.stb && bus.we;
      for (int i = 0; i < NIRQ; i++) begin
        if (m_edge[i]) begin
          if (wr && bus.addr == 3'd0 && bus.dtw[i]) np[i] = 1'b0;
          if (m_intrq && intack && m_vec == i) np[i] = 1'b0;
          if (samp[i] && !m_prev[i]) np[i] = 1'b1;
        end else begin
          np[i] = samp[i];
        end
      end
      if (wr && bus.addr == 3'd1) ne = bus.dtw[NIRQ-1:0];
      if (wr && bus.addr == 3'd2) ned = bus.dtw[NIRQ-1:0];
      pe = m_pend & m_en;
      if (m_busy) begin
        if (wr && bus.addr == 3'd4) nb = 1'b0;
      end else if (m_intrq && intack) begin
        nb = 1'b1; na = m_vec; ni = 1'b0;
      end else begin
        nv = lowest(pe); ni = (pe != '0);
      end
    end
    @(posedge clk);
    #1;
    if (was_reset) begin
      model_reset();
    end else begin
      m_pend = np; m_en = ne; m_edge = ned; m_prev = samp;
      m_busy = nb; m_intrq = ni; m_vec = nv; m_av = na;
    end
    check("model_intrq", intrq, m_intrq);
    check("model_vec", vec, m_vec);
    check("model_dtr", bus.dtr, exp_read(int'(bus.addr)));
    check("ack", bus.ack, bus.stb);
  endtask

  task automatic wr(input int a, input bit [31:0] d);
    bus.stb = 1'b1; bus.we = 1'b1; bus.addr = 3'(a); bus.dtw = d;
    cycle();
    bus.stb = 1'b0; bus.we = 1'b0; bus.dtw = '0;
  endtask

  task automatic chk_rd(input string name, input int a, input bit [31:0] exp);
    bus.addr = 3'(a);
    #1;
    check(name, bus.dtr, exp);
  endtask

  task automatic pulse(input bit [NIRQ-1:0] lines);
    irq_in = lines;
    cycle();
    irq_in = '0;
  endtask

  task automatic take();
    intack = 1'b1;
    cycle();
    intack = 1'b0;
  endtask

  initial begin
    int idx;
    reset = 1'b1; irq_in = '0; intack = 1'b0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.dtw = '0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("reset_intrq", intrq, 1'b0);
    check("reset_vec", vec, 5'd0);
    for (int a = 0; a < 8; a++) chk_rd("reset_reg", a, 32'h0);

    // Register map vectors (no interrupt activity).
    tbl.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h00FF_FFFF});
    tbl.push_back('{1'b1, 3'd2, 32'hA5A5_A5A5, 32'h00A5_A5A5});
    tbl.push_back('{1'b0, 3'd0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd3, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 3'd6, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd7, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_1234, 32'h0000_1234});
    tbl.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 3'd4, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd2, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h0, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].we) wr(int'(tbl[i].addr), tbl[i].dtw);
      chk_rd("regmap", int'(tbl[i].addr), tbl[i].exp);
    end

    // Edge path on line 0, latency 2 (+2 with the synchronizer).
    wr(2, 32'h1); wr(1, 32'h1);
    pulse(24'h1);
    repeat (SYNC_D) cycle();
    chk_rd("edge_pend", 0, 32'h1);
    check("edge_intrq_early", intrq, 1'b0);
    cycle();
    check("edge_intrq", intrq, 1'b1);
    check("edge_vec", vec, 5'd0);
    take();
    check("edge_ack_intrq", intrq, 1'b0);
    chk_rd("edge_ack_pend", 0, 32'h0);
    chk_rd("edge_ack_status", 3, 32'h100);
    wr(4, 32'h0);
    chk_rd("edge_eoi_status", 3, 32'h0);

    // Priority: lines 5 and 2 together, then 5 after EOI.
    wr(2, 32'hFF_FFFF); wr(1, 32'hFF_FFFF);
    pulse(24'h24);
    repeat (SYNC_D + 1) cycle();
    check("prio_intrq", intrq, 1'b1);
    check("prio_vec", vec, 5'd2);
    chk_rd("prio_pend", 0, 32'h24);
    take();
    chk_rd("prio_status", 3, 32'h102);
    chk_rd("prio_pend_left", 0, 32'h20);
    wr(4, 32'h0);
    check("prio_eoi_p1", intrq, 1'b0);
    cycle();
    check("prio_eoi_p2_intrq", intrq, 1'b1);
    check("prio_eoi_p2_vec", vec, 5'd5);
    take();
    wr(4, 32'h0);
    chk_rd("prio_done_status", 3, 32'h5);

    // Masked level line, then enable, then drop before intack.
    wr(1, 32'h0); wr(2, 32'h0);
    irq_in = 24'h8;
    repeat (SYNC_D + 2) cycle();
    chk_rd("lvl_pend", 0, 32'h8);
    check("lvl_masked_intrq", intrq, 1'b0);
    wr(0, 32'h8);
    chk_rd("lvl_w1c_noeffect", 0, 32'h8);
    wr(1, 32'h8);
    cycle();
    check("lvl_en_intrq", intrq, 1'b1);
    check("lvl_en_vec", vec, 5'd3);
    irq_in = '0;
    repeat (SYNC_D + 2) cycle();
    check("lvl_drop_intrq", intrq, 1'b0);
    chk_rd("lvl_drop_pend", 0, 32'h0);

    // W1C racing a new edge on line 4; stray intack and EOI in idle.
    wr(1, 32'h0); wr(2, 32'h10);
    pulse(24'h10);
    repeat (SYNC_D + 1) cycle();
    chk_rd("race_pend_set", 0, 32'h10);
    irq_in = 24'h10;
    repeat (SYNC_D) cycle();
    wr(0, 32'h10);
    irq_in = '0;
    chk_rd("race_edge_wins", 0, 32'h10);
    wr(0, 32'h10);
    chk_rd("w1c_clear", 0, 32'h0);
    take();
    check("stray_ack_intrq", intrq, 1'b0);
    chk_rd("stray_ack_status", 3, 32'h5);
    wr(4, 32'h0);
    chk_rd("stray_eoi_status", 3, 32'h5);

    // Reset while in service on vector 7.
    wr(2, 32'h80); wr(1, 32'h80);
    pulse(24'h80);
    repeat (SYNC_D + 1) cycle();
    check("rst_pre_vec", vec, 5'd7);
    take();
    chk_rd("rst_pre_status", 3, 32'h107);
    reset = 1'b1;
    cycle();
    for (int a = 0; a < 8; a++) chk_rd("rst_held_rd", a, 32'h0);
    reset = 1'b0;
    cycle();
    check("rst_intrq", intrq, 1'b0);
    for (int a = 0; a < 4; a++) chk_rd("rst_regs", a, 32'h0);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) begin
        idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NIRQ - 1))
                                          : int'($urandom_range(0, 7));
        irq_in[idx] = ~irq_in[idx];
      end
      intack  = ($urandom_range(0, 3) == 0);
      bus.stb = ($urandom_range(0, 2) == 0);
      bus.we  = ($urandom_range(0, 1) == 0);
      bus.addr = 3'($urandom_range(0, 7));
      bus.dtw  = $urandom;
      cycle();
    end
    bus.stb = 1'b0; bus.we = 1'b0; intack = 1'b0; reset = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
